// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch-to-decode handshake bundle for the instruction fetch queue
interface inst_fetch_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;

    // master: the fetch/decode side driving offers and consumption
    modport master (
        output in_valid, in_pc, in_inst, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_pred_taken
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_pred_taken
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular instruction queue between fetch and decode with one-cycle flush
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    inst_fetch_queue_if.slave    bus,
    output logic [PTR_W:0]       o_count
);
    localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);
    localparam logic [31:0]      LP_NOP     = 32'h0000_0013;

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic             r_pred [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready/valid come from registered occupancy only, so no input-to-output combinational path.
    assign w_in_ready  = (r_cnt != LP_FULL);
    assign w_out_valid = (r_cnt != '0);
    assign w_push      = bus.in_valid  && w_in_ready  && !i_flush && !i_rst;
    assign w_pop       = bus.out_ready && w_out_valid && !i_flush && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + LP_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - LP_CNT_ONE;
            end
        end
    end

    // Entry storage is never cleared; stale contents are hidden by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]   <= bus.in_pc;
            r_inst[r_wr_ptr] <= bus.in_inst;
            r_pred[r_wr_ptr] <= bus.in_pred_taken;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_pc         = w_out_valid ? r_pc[r_rd_ptr]   : 32'h0;
    assign bus.out_inst       = w_out_valid ? r_inst[r_rd_ptr] : LP_NOP;
    assign bus.out_pred_taken = w_out_valid ? r_pred[r_rd_ptr] : 1'b0;
    assign o_count            = r_cnt;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed bench with queue-based reference model for inst_fetch_queue
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk;
    logic rst;
    logic flush;
    logic [PTR_W:0] count;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus),
        .o_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } entry_t;

    entry_t mq[$];
    int     n_checks = 0;
    int     n_errors = 0;
    logic   chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: refusal when full, no bypass either way, reset/flush empty it.
    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            automatic bit do_push = bus.in_valid && (mq.size() < DEPTH);
            automatic bit do_pop  = bus.out_ready && (mq.size() > 0);
            automatic entry_t e;
            e.pc = bus.in_pc; e.inst = bus.in_inst; e.pred = bus.in_pred_taken;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  {31'd0, bus.in_ready},  {31'd0, mq.size() < DEPTH});
            chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
            chk("m_count",     {29'd0, count},         32'(mq.size()));
            if (mq.size() > 0) begin
                chk("m_out_pc",   bus.out_pc,   mq[0].pc);
                chk("m_out_inst", bus.out_inst, mq[0].inst);
                chk("m_out_pred", {31'd0, bus.out_pred_taken}, {31'd0, mq[0].pred});
            end else begin
                chk("m_out_pc_e",   bus.out_pc,   32'h0);
                chk("m_out_inst_e", bus.out_inst, 32'h13);
                chk("m_out_pred_e", {31'd0, bus.out_pred_taken}, 32'h0);
            end
        end
    end

    // Drive one cycle of inputs from a negedge, return at the next negedge.
    task automatic cyc(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic pred, input logic ordy);
        flush = fl;
        bus.in_valid = iv;
        bus.in_pc = pc;
        bus.in_inst = inst;
        bus.in_pred_taken = pred;
        bus.out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc = '0;
        bus.in_inst = '0;
        bus.in_pred_taken = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_count",     {29'd0, count}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_pc",    bus.out_pc, 32'h0);
        chk("rst_out_inst",  bus.out_inst, 32'h13);

        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 32'h100 + 32'(4*k), 32'hA000 + 32'(k), k[0], 0);
            chk("fill_count", {29'd0, count}, 32'(k + 1));
        end
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        cyc(0, 1, 32'h110, 32'hA004, 0, 0);
        chk("refused_count", {29'd0, count}, 32'd4);
        chk("refused_head",  bus.out_pc, 32'h100);

        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", bus.out_pc, 32'h100 + 32'(4*k));
            cyc(0, 0, 0, 0, 0, 1);
        end
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain_inst",  bus.out_inst, 32'h13);

        cyc(0, 1, 32'h200, 32'd0, 0, 1);
        for (int k = 1; k < 10; k++) begin
            chk("wrap_pc",   bus.out_pc,   32'h200 + 32'(4*(k-1)));
            chk("wrap_inst", bus.out_inst, 32'(k - 1));
            cyc(0, 1, 32'h200 + 32'(4*k), 32'(k), k[0], 1);
            chk("wrap_count", {29'd0, count}, 32'd1);
        end
        chk("wrap_last", bus.out_pc, 32'h224);
        cyc(0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h280 + 32'(4*k), 32'h280, 1, 0);
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        cyc(1, 1, 32'h300, 32'h300, 1, 1);
        chk("flush_count",    {29'd0, count}, 32'd0);
        chk("flush_valid",    {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc(0, 1, 32'h400, 32'h400, 0, 0);
        chk("post_flush_head", bus.out_pc, 32'h400);
        cyc(0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 4; k++) cyc(0, 1, 32'h500 + 32'(4*k), 32'h500, 0, 0);
        chk("fp_full", {29'd0, count}, 32'd4);
        cyc(0, 1, 32'h510, 32'h510, 1, 1);
        chk("fp_count",  {29'd0, count}, 32'd3);
        chk("fp_head",   bus.out_pc, 32'h504);
        cyc(0, 1, 32'h510, 32'h510, 1, 0);
        chk("fp_accept", {29'd0, count}, 32'd4);
        for (int k = 1; k < 5; k++) begin
            chk("fp_drain", bus.out_pc, 32'h500 + 32'(4*k));
            cyc(0, 0, 0, 0, 0, 1);
        end

        cyc(0, 1, 32'h600, 32'h600, 0, 0);
        cyc(0, 1, 32'h604, 32'h604, 0, 0);
        chk("pre_rst_count", {29'd0, count}, 32'd2);
        rst = 1'b1;
        cyc(0, 1, 32'h700, 32'h700, 0, 0);
        rst = 1'b0;
        chk("mrst_count",    {29'd0, count}, 32'd0);
        chk("mrst_valid",    {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h800, 32'h800, 0, 0);
        chk("mrst_new_head", bus.out_pc, 32'h800);
        cyc(0, 0, 0, 0, 0, 1);
        chk("end_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the fetch stage and the decode stage of the tinyriscv pipeline. The fetch stage pushes each fetched instruction word with its PC and branch-prediction bit. The decode stage pops them in order through a valid/ready handshake. A flush input, driven by the resolved branch flag, discards every queued entry in one cycle so that wrong-path instructions never reach decode.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- PTR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all entries (branch_flag from execute)
- in_valid  input  1  fetch stage offers an entry
- in_ready  output  1  queue can accept an entry this cycle
- in_pc  input  32  PC of offered instruction
- in_inst  input  32  instruction word
- in_pred_taken  input  1  fetch-stage branch prediction for this instruction
- out_valid  output  1  head entry present
- out_ready  input  1  decode stage consumes head this cycle
- out_pc  output  32  head PC
- out_inst  output  32  head instruction word
- out_pred_taken  output  1  head prediction bit
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0], pred_taken}, circular buffer with rd_ptr and wr_ptr (PTR_W bits, wrap modulo DEPTH), plus an occupancy counter cnt (PTR_W+1 bits).
- Push happens when in_valid && in_ready && !flush: write entry at wr_ptr, wr_ptr+1.
- Pop happens when out_valid && out_ready && !flush: rd_ptr+1.
- Both in the same cycle: cnt unchanged, both pointers advance. Legal at any occupancy 1..DEPTH-1.
- in_ready = (cnt != DEPTH). There is no same-cycle pop-to-push bypass: when full, a push is refused even if out_ready is high.
- out_valid = (cnt != 0). No empty bypass: an entry pushed into an empty queue is not visible until the next cycle.
- Outputs when out_valid=1 are combinational reads of the entry at rd_ptr.
- Outputs when empty: out_pc = 0, out_inst = 32'h00000013 (NOP), out_pred_taken = 0.
- Flush: at the clock edge, cnt, rd_ptr and wr_ptr all go to 0. Any push or pop offered in that cycle is ignored, and nothing from the flush cycle enters the queue. Entry contents are not cleared. in_ready and out_valid are not gated combinationally by flush.
- Priority: rst > flush > push/pop.
- in_valid while in_ready=0: no state change. The upstream stage holds its offer.
- Reset values: cnt=0, rd_ptr=0, wr_ptr=0. Resulting outputs: in_ready=1, out_valid=0, count=0, out_pc=0, out_inst=32'h00000013, out_pred_taken=0.
- Reset mid-operation: every queued entry is lost, and behaviour is identical to flush.

## Timing
- Push-to-visible latency is 1 cycle. An entry accepted at edge N is at the head (if the queue was empty) from edge N to edge N+1.
- Sustained throughput is one push and one pop per cycle once the queue is non-empty.
- in_ready, out_valid and count are derived from registered state only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.
- out_pc/out_inst/out_pred_taken depend combinationally on rd_ptr and storage only.
- Flush at edge N: out_valid=0 and in_ready=1 after edge N. A push at edge N+1 is visible after edge N+1.
- Pointer wrap: after index DEPTH-1 the pointer goes to 0. No bubble and no reordering across the wrap.

## Test plan
- Reset then fill. Hold rst for 2 cycles. Push PCs 0x100, 0x104, 0x108, 0x10C with out_ready=0. Required: count goes 1→4, in_ready=0 after the 4th push, and a 5th offer (0x110) is refused, leaving count=4.
- In-order drain. From full, set out_ready=1 for 4 cycles. Required: out_pc reads 0x100, 0x104, 0x108, 0x10C on successive cycles. After that, out_valid=0 and out_inst=0x00000013.
- Wrap-around streaming. Push and pop continuously for 10 entries, PCs 0x200+4k with inst=k. Required: count stays at 1 after the first cycle, and the output sequence matches the input exactly across pointer wrap.
- Flush with concurrent traffic. With count=3, assert flush together with in_valid=1 (PC 0x300) and out_ready=1. Required: next cycle count=0 and out_valid=0, and 0x300 never appears at the output. A push of 0x400 on the following cycle appears as the head one cycle later.
- Full plus pop, no bypass. Full queue, in_valid=1 and out_ready=1 in the same cycle. Required: the pop occurs, the push is refused, and count goes to 3. The push is accepted on the next cycle.
- Reset mid-stream. With count=2, assert rst together with flush=0, in_valid=1 and out_ready=0. Required: count=0, out_valid=0 and in_ready=1 after the edge, and neither the prior entries nor the offered entry ever appear at the output.
